// File: rtl/lobinho_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lobinho_pkg - shared state codes and phase constants (Rev 1.0)     |
// +--------------------------------------------------------------------+
package lobinho_pkg;

   // Codes are also decoded by the debug display, keep them stable
   typedef enum logic [4:0] {
      EST_INICIAL    = 5'h00,
      EST_PREPARA    = 5'h01,
      EST_BUSCA      = 5'h02,
      EST_VEZ        = 5'h03,
      EST_AVANCA     = 5'h04,
      EST_FIM_RODADA = 5'h05
   } estado_t;

   localparam logic FASE_NOITE = 1'b0;
   localparam logic FASE_DIA   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/controlador_turnos_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | controlador_turnos_if - game-control <-> turn scheduler (Rev 1.0)  |
// +--------------------------------------------------------------------+
interface controlador_turnos_if #(
   parameter int N_JOGADORES = 8,
   parameter int W_ID        = $clog2(N_JOGADORES)
);
   logic                   iniciar;
   logic                   passa;
   logic [N_JOGADORES-1:0] vivos;
   logic [W_ID-1:0]        jogador_atual;
   logic                   vez_valida;
   logic                   fase;
   logic                   timeout_vez;
   logic                   fim_rodada;
   logic [4:0]             db_estado;

   modport master (
      output iniciar, passa, vivos,
      input  jogador_atual, vez_valida, fase, timeout_vez, fim_rodada, db_estado
   );

   modport slave (
      input  iniciar, passa, vivos,
      output jogador_atual, vez_valida, fase, timeout_vez, fim_rodada, db_estado
   );
endinterface
`default_nettype wire

// File: rtl/controlador_turnos_contador_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | contador_timeout - per-turn cycle counter, saturates at limit (1.0)|
// +--------------------------------------------------------------------+
module contador_timeout #(
   parameter int TIMEOUT = 50000000,
   parameter int W_T     = $clog2(TIMEOUT)
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);
   localparam logic [W_T-1:0] LIMITE = W_T'(TIMEOUT - 1);

   logic [W_T-1:0] count_q;
   logic [W_T-1:0] count_d;

   assign fim = (count_q == LIMITE);

   always_comb begin
      count_d = count_q;
      if (zera) begin
         count_d = '0;
      end else if (conta && !fim) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/controlador_turnos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | controlador_turnos - round-robin turn scheduler for alive players  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module controlador_turnos
   import lobinho_pkg::*;
#(
   parameter int N_JOGADORES = 8,
   parameter int TIMEOUT     = 50000000
) (
   input  logic                 clock,
   input  logic                 reset,
   controlador_turnos_if.slave  bus
);
   localparam int              W_ID    = $clog2(N_JOGADORES);
   localparam int              W_T     = $clog2(TIMEOUT);
   localparam logic [W_ID-1:0] ULTIMO  = W_ID'(N_JOGADORES - 1);

   estado_t         estado_q, estado_d;
   logic [W_ID-1:0] idx_q, idx_d;
   logic            fase_q, fase_d;
   logic            flag_q, flag_d;
   logic            zera;
   logic            conta;
   logic            fim_timer;

   contador_timeout #(
      .TIMEOUT (TIMEOUT),
      .W_T     (W_T)
   ) u_contador_timeout (
      .clock (clock),
      .reset (reset),
      .zera  (zera),
      .conta (conta),
      .fim   (fim_timer)
   );

   always_comb begin
      estado_d = estado_q;
      idx_d    = idx_q;
      fase_d   = fase_q;
      flag_d   = flag_q;
      zera     = 1'b0;
      conta    = 1'b0;
      case (estado_q)
         EST_INICIAL: begin
            if (bus.iniciar) estado_d = EST_PREPARA;
         end
         EST_PREPARA: begin
            idx_d    = '0;
            estado_d = EST_BUSCA;
         end
         EST_BUSCA: begin
            if (bus.vivos[idx_q]) begin
               estado_d = EST_VEZ;
               zera     = 1'b1;
            end else if (idx_q == ULTIMO) begin
               estado_d = EST_FIM_RODADA;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         EST_VEZ: begin
            // passa beats a coincident timeout; a killed player leaves silently
            if (bus.passa || !bus.vivos[idx_q]) begin
               estado_d = EST_AVANCA;
            end else if (fim_timer) begin
               estado_d = EST_AVANCA;
               flag_d   = 1'b1;
            end else begin
               conta = 1'b1;
            end
         end
         EST_AVANCA: begin
            flag_d = 1'b0;
            if (idx_q == ULTIMO) begin
               estado_d = EST_FIM_RODADA;
            end else begin
               idx_d    = idx_q + 1'b1;
               estado_d = EST_BUSCA;
            end
         end
         EST_FIM_RODADA: begin
            fase_d   = ~fase_q;
            estado_d = (bus.vivos == '0) ? EST_INICIAL : EST_PREPARA;
         end
         default: estado_d = EST_INICIAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= EST_INICIAL;
         idx_q    <= '0;
         fase_q   <= FASE_NOITE;
         flag_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         idx_q    <= idx_d;
         fase_q   <= fase_d;
         flag_q   <= flag_d;
      end
   end

   assign bus.jogador_atual = idx_q;
   assign bus.vez_valida    = (estado_q == EST_VEZ);
   assign bus.fase          = fase_q;
   assign bus.timeout_vez   = (estado_q == EST_AVANCA) && flag_q;
   assign bus.fim_rodada    = (estado_q == EST_FIM_RODADA);
   assign bus.db_estado     = estado_q;
endmodule
`default_nettype wire

// File: tb/tb_controlador_turnos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_controlador_turnos - directed self-checking bench (Rev 1.0)     |
// +--------------------------------------------------------------------+
module tb_controlador_turnos;
   localparam int N_JOGADORES = 8;
   localparam int TIMEOUT     = 16;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   n;

   controlador_turnos_if #(.N_JOGADORES(N_JOGADORES)) bus ();

   controlador_turnos #(
      .N_JOGADORES (N_JOGADORES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_tests++;
      if (obs !== esp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic aplica_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic espera_vez(output int ciclos);
      ciclos = 0;
      do begin
         tick();
         ciclos++;
      end while (!bus.vez_valida && ciclos < 40);
      if (!bus.vez_valida) verifica("espera_vez", 32'd0, 32'd1);
   endtask

   task automatic passar();
      bus.passa = 1'b1;
      tick();
      bus.passa = 1'b0;
   endtask

   task automatic inicia();
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      reset       = 1'b1;
      bus.iniciar = 1'b0;
      bus.passa   = 1'b0;
      bus.vivos   = 8'hFF;

      // Reset values
      aplica_reset();
      verifica("rst_estado",  32'(bus.db_estado),     32'h00);
      verifica("rst_jogador", 32'(bus.jogador_atual), 32'd0);
      verifica("rst_fase",    32'(bus.fase),          32'd0);
      verifica("rst_vez",     32'(bus.vez_valida),    32'd0);
      verifica("rst_timeout", 32'(bus.timeout_vez),   32'd0);
      verifica("rst_fim",     32'(bus.fim_rodada),    32'd0);

      // Full round, everyone alive
      inicia();
      espera_vez(n);
      verifica("lat_inicio", 32'(n + 1), 32'd3);
      verifica("vez_estado", 32'(bus.db_estado), 32'h03);
      for (int p = 0; p < N_JOGADORES; p++) begin
         if (p > 0) begin
            espera_vez(n);
            verifica("lat_vez", 32'(n), 32'd2);
         end
         verifica("ff_jogador", 32'(bus.jogador_atual), 32'(p));
         tick();
         passar();
         verifica("ff_avanca", 32'(bus.db_estado), 32'h04);
      end
      tick();
      verifica("ff_fim_pulso", 32'(bus.fim_rodada), 32'd1);
      verifica("ff_fim_estado", 32'(bus.db_estado), 32'h05);
      verifica("ff_fase_antes", 32'(bus.fase), 32'd0);
      tick();
      verifica("ff_fim_baixo", 32'(bus.fim_rodada), 32'd0);
      verifica("ff_fase_dia", 32'(bus.fase), 32'd1);
      espera_vez(n);
      verifica("ff_reinicio_lat", 32'(n), 32'd2);
      verifica("ff_reinicio_jog", 32'(bus.jogador_atual), 32'd0);

      // Sparse mask: players 2, 5, 7
      aplica_reset();
      bus.vivos = 8'b1010_0100;
      inicia();
      espera_vez(n);
      verifica("esp_lat2", 32'(n), 32'd4);
      verifica("esp_jog2", 32'(bus.jogador_atual), 32'd2);
      passar();
      espera_vez(n);
      verifica("esp_lat5", 32'(n), 32'd4);
      verifica("esp_jog5", 32'(bus.jogador_atual), 32'd5);
      passar();
      espera_vez(n);
      verifica("esp_lat7", 32'(n), 32'd3);
      verifica("esp_jog7", 32'(bus.jogador_atual), 32'd7);
      passar();
      tick();
      verifica("esp_fim", 32'(bus.fim_rodada), 32'd1);

      // Timeout on player 0, then passa on the last timer cycle of player 1
      aplica_reset();
      bus.vivos = 8'hFF;
      inicia();
      espera_vez(n);
      repeat (TIMEOUT - 1) tick();
      verifica("to_ainda_vez", 32'(bus.db_estado), 32'h03);
      verifica("to_sem_pulso", 32'(bus.timeout_vez), 32'd0);
      tick();
      verifica("to_pulso", 32'(bus.timeout_vez), 32'd1);
      verifica("to_avanca", 32'(bus.db_estado), 32'h04);
      tick();
      verifica("to_pulso_unico", 32'(bus.timeout_vez), 32'd0);
      tick();
      verifica("to_prox_vez", 32'(bus.vez_valida), 32'd1);
      verifica("to_prox_jog", 32'(bus.jogador_atual), 32'd1);
      repeat (TIMEOUT - 1) tick();
      verifica("pl_ainda_vez", 32'(bus.db_estado), 32'h03);
      passar();
      verifica("pl_sem_pulso", 32'(bus.timeout_vez), 32'd0);
      verifica("pl_avanca", 32'(bus.db_estado), 32'h04);

      // All dead: scan, close round, back to idle with day phase
      aplica_reset();
      bus.vivos = 8'h00;
      inicia();
      for (int k = 0; k < N_JOGADORES; k++) begin
         tick();
         verifica("morto_busca", 32'(bus.db_estado), 32'h02);
      end
      tick();
      verifica("morto_fim", 32'(bus.fim_rodada), 32'd1);
      tick();
      verifica("morto_inicial", 32'(bus.db_estado), 32'h00);
      verifica("morto_fase", 32'(bus.fase), 32'd1);

      // Player 3 killed mid-turn, then reset during player 4's turn
      bus.vivos = 8'hFF;
      inicia();
      for (int p = 0; p < 4; p++) begin
         espera_vez(n);
         verifica("mata_jog", 32'(bus.jogador_atual), 32'(p));
         if (p < 3) passar();
      end
      verifica("mata_fase", 32'(bus.fase), 32'd1);
      bus.vivos = 8'hF7;
      tick();
      verifica("mata_avanca", 32'(bus.db_estado), 32'h04);
      verifica("mata_sem_to", 32'(bus.timeout_vez), 32'd0);
      bus.vivos = 8'hFF;
      espera_vez(n);
      verifica("mata_lat4", 32'(n), 32'd2);
      verifica("mata_jog4", 32'(bus.jogador_atual), 32'd4);
      reset = 1'b1;
      tick();
      verifica("rv_estado",  32'(bus.db_estado),     32'h00);
      verifica("rv_jogador", 32'(bus.jogador_atual), 32'd0);
      verifica("rv_fase",    32'(bus.fase),          32'd0);
      verifica("rv_vez",     32'(bus.vez_valida),    32'd0);
      verifica("rv_timeout", 32'(bus.timeout_vez),   32'd0);
      verifica("rv_fim",     32'(bus.fim_rodada),    32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/controlador_turnos.md
Name: controlador_turnos

Overview:
- Turn scheduler for the PoliLobinho game: hands the shared player-input/display datapath to one living player at a time.
- Walks player indices in ascending order each round, skipping dead players. Each turn is bounded by a timeout.
- Toggles the night/day phase at the end of every round.
- Sits beside the main game control unit. That unit asserts `iniciar` and supplies the alive mask; this block drives whose turn it is.

Parameters:
- N_JOGADORES, 8, number of player slots (≥2).
- TIMEOUT, 50000000, clock cycles allowed per turn (≥2).
- W_ID, clog2(N_JOGADORES), width of the player index.
- W_T, clog2(TIMEOUT), width of the turn timer.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start a game of rounds (sampled only in INICIAL).
- passa  in  1  current player ends turn (1-cycle pulse, from button edge detector).
- vivos  in  N_JOGADORES  alive mask, bit i = player i alive; sampled every cycle.
- jogador_atual  out  W_ID  index of player whose turn it is.
- vez_valida  out  1  high while a turn is open (state VEZ).
- fase  out  1  0 = night, 1 = day.
- timeout_vez  out  1  one-cycle pulse: turn ended by timeout.
- fim_rodada  out  1  one-cycle pulse: round complete.
- db_estado  out  5  state code for debug displays.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs, legal at any time including mid-turn): state INICIAL. Output reset values:
  - jogador_atual=0, fase=0, timer=0
  - vez_valida=0, timeout_vez=0, fim_rodada=0
- States and db_estado codes:
  - INICIAL 5'h00: idle; iniciar=1 → PREPARA.
  - PREPARA 5'h01: idx←0 → BUSCA.
  - BUSCA 5'h02: one index examined per cycle.
    - vivos[idx]=1 → VEZ, timer←0.
    - else if idx=N_JOGADORES-1 → FIM_RODADA.
    - else idx←idx+1, stay.
  - VEZ 5'h03: vez_valida=1. Priority order, first match wins:
    - passa=1 → AVANCA.
    - vivos[idx]=0 (player killed mid-turn) → AVANCA, no timeout pulse.
    - timer=TIMEOUT-1 → AVANCA, set timeout flag.
    - otherwise timer←timer+1.
  - AVANCA 5'h04: timeout_vez = flag (registered, high only this cycle); flag cleared.
    - idx=N_JOGADORES-1 → FIM_RODADA.
    - else idx←idx+1 → BUSCA.
  - FIM_RODADA 5'h05: fim_rodada=1 for exactly this cycle; fase←~fase.
    - vivos=0 → INICIAL.
    - else → PREPARA.
  - Unused codes → INICIAL.
- jogador_atual = idx register at all times. It is meaningful to consumers only when vez_valida=1.
- Latency:
  - iniciar to first VEZ (player 0 alive): 3 edges (INICIAL→PREPARA→BUSCA→VEZ).
  - Each dead player skipped costs 1 cycle.
  - passa in VEZ to next VEZ with an adjacent alive player: 3 cycles (AVANCA, BUSCA, VEZ).
- Turn length: timeout fires when passa is absent for TIMEOUT cycles in VEZ (timer values 0..TIMEOUT-1).
- Simultaneous events: passa and last timer cycle together → passa wins, no timeout_vez. passa outside VEZ is ignored; iniciar outside INICIAL is ignored.
- All-dead mask at round start → BUSCA scans to N-1 and goes to FIM_RODADA, then INICIAL.
- Alive mask changes are honoured immediately in BUSCA/VEZ. No internal copy of the mask is kept.
- Timer never wraps: it is cleared on VEZ entry and saturates at the decision point.

Decomposition:
- Package lobinho_pkg:
  - state encodings (5-bit codes above, shared with the debug display decoder)
  - FASE_NOITE=0, FASE_DIA=1
- One natural sub-module, contador_timeout:
  - W_T-bit counter with synchronous clear (zera) and enable (conta)
  - output fim = (count==TIMEOUT-1)
- The FSM and idx register stay in controlador_turnos.

Test Plan (TIMEOUT=16, N_JOGADORES=8 for simulation):
- Reset then iniciar with vivos=8'hFF, passa 2 cycles after each VEZ entry → jogador_atual steps 0..7, db_estado 3 on first VEZ 3 cycles after iniciar, fim_rodada pulse once, fase 0→1, round restarts at player 0.
- vivos=8'b1010_0100 → turns only for players 2, 5, 7; BUSCA dwells 2 cycles before player 2, 2 before 5, 1 before 7.
- No passa in player 0's turn → after 16 VEZ cycles timeout_vez pulses once in AVANCA, next turn is player 1; passa on timer=15 instead → no timeout_vez.
- Clear vivos[3] while player 3 in VEZ → exits to AVANCA next edge, timeout_vez=0, player 4 gets the turn.
- vivos=8'h00 at iniciar → BUSCA 8 cycles, fim_rodada pulse, back to INICIAL (db_estado 0), fase=1.
- Assert reset during VEZ of player 4 with fase=1 → next cycle db_estado=0, jogador_atual=0, fase=0, all pulses low.
